multicycle_controller: RTL and testbench

Main control state machine for the multicycle MIPS core. It sequences the shared-memory datapath through fetch, decode, execute, memory and writeback steps, one micro-step per clock. It drives every datapath mux select, write strobe and ALU operation from the instruction register's opcode/funct fields and the ALU zero flag. It replaces the single-cycle controller at the core top level.

---
 rtl/multicycle_controller.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM for the multicycle MIPS core.
// It steps the shared-memory datapath through fetch, decode, execute, memory
// and writeback, one micro-step per clock.
// Most control outputs are registered. They are computed from the next state
// and the IR fields, so they line up with the state register.
// pcen and illegal stay combinational: pcen must follow zero in the same
// cycle, and illegal must see the IR fields that were just loaded during FETCH.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       signorzero,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    BNEEX   = 4'd9,
    IMMEX   = 4'd10,
    IMMWB   = 4'd11,
    JEX     = 4'd12
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       signorzero;
  } ctl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t st, nxt;
  ctl_t   ctl;
  logic   functok, legal;

  // R-type funct decode into an ALU operation; unsupported funct yields ok=0
  function automatic logic [3:0] rfunct(input logic [5:0] f);
    case (f)
      6'b100000: rfunct = 4'b1_010;
      6'b100010: rfunct = 4'b1_110;
      6'b100100: rfunct = 4'b1_000;
      6'b100101: rfunct = 4'b1_001;
      6'b101010: rfunct = 4'b1_111;
      default:   rfunct = 4'b0_010;
    endcase
  endfunction

  // Moore control word for a given state and IR fields
  function automatic ctl_t decode_ctl(input state_t s, input logic [5:0] o,
                                      input logic [5:0] f);
    logic [3:0] rf;
    ctl_t c;
    rf = rfunct(f);
    c = '0;
    c.alucontrol = 3'b010;
    case (s)
      FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
      DECODE:  c.alusrcb = 2'b11;
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:   c.iord = 1'b1;
      MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      RTYPEEX: begin c.alusrca = 1'b1; c.alucontrol = rf[2:0]; end
      RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BEQEX, BNEEX: begin
        c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01;
      end
      IMMEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        case (o)
          OP_SLTI: c.alucontrol = 3'b111;
          OP_ANDI: begin c.alucontrol = 3'b000; c.signorzero = 1'b1; end
          OP_ORI:  begin c.alucontrol = 3'b001; c.signorzero = 1'b1; end
          default: c.alucontrol = 3'b010;
        endcase
      end
      IMMWB:   c.regwrite = 1'b1;
      JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  // opcode/funct legality, used both for dispatch and the illegal pulse
  always_comb begin
    functok = rfunct(funct)[3];
    case (op)
      OP_R:                            legal = functok;
      OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_SLTI, OP_ANDI,
      OP_ORI, OP_J:                    legal = 1'b1;
      default:                         legal = 1'b0;
    endcase
  end

  // next-state logic; stray encodings fall back to FETCH
  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:  nxt = DECODE;
      DECODE: begin
        if (!legal)                             nxt = FETCH;
        else case (op)
          OP_LW, OP_SW:                         nxt = MEMADR;
          OP_R:                                 nxt = RTYPEEX;
          OP_BEQ:                               nxt = BEQEX;
          OP_BNE:                               nxt = BNEEX;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:    nxt = IMMEX;
          OP_J:                                 nxt = JEX;
          default:                              nxt = FETCH;
        endcase
      end
      MEMADR:  nxt = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   nxt = MEMWB;
      RTYPEEX: nxt = RTYPEWB;
      IMMEX:   nxt = IMMWB;
      default: nxt = FETCH;
    endcase
  end

  // state register plus registered control word for the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= FETCH;
      ctl <= decode_ctl(FETCH, 6'b0, 6'b0);
    end else begin
      st  <= nxt;
      ctl <= decode_ctl(nxt, op, funct);
    end
  end

  // Write strobes are gated by reset so that an aborted instruction cannot
  // write anything while reset is high.
  assign pcen       = ~reset & (ctl.pcwrite | ((st == BEQEX) & zero)
                                            | ((st == BNEEX) & ~zero));
  assign irwrite    = ~reset & ctl.irwrite;
  assign memwrite   = ~reset & ctl.memwrite;
  assign regwrite   = ~reset & ctl.regwrite;
  assign illegal    = ~reset & (st == DECODE) & ~legal;
  assign iord       = ctl.iord;
  assign memtoreg   = ctl.memtoreg;
  assign regdst     = ctl.regdst;
  assign alusrca    = ctl.alusrca;
  assign alusrcb    = ctl.alusrcb;
  assign pcsrc      = ctl.pcsrc;
  assign alucontrol = ctl.alucontrol;
  assign signorzero = ctl.signorzero;
  assign state      = st;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through its state sequence and checks key control outputs on the negedge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pcen, iord, irwrite, memwrite, regwrite, memtoreg, regdst;
  logic       alusrca, signorzero, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
    .regwrite(regwrite), .memtoreg(memtoreg), .regdst(regdst),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .signorzero(signorzero), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; op = 6'b100011; funct = 6'b0; zero = 1'b0;
    @(negedge clk);
    // reset state
    chk("rst_state",   8'(state), 8'd0);
    chk("rst_pcen",    8'(pcen), 8'd0);
    chk("rst_irwrite", 8'(irwrite), 8'd0);
    chk("rst_alusrcb", 8'(alusrcb), 8'd1);
    chk("rst_aluctl",  8'(alucontrol), 8'd2);
    chk("rst_illegal", 8'(illegal), 8'd0);
    reset = 1'b0;
    #1;
    chk("fetch_irwrite", 8'(irwrite), 8'd1);
    chk("fetch_pcen",    8'(pcen), 8'd1);

    // lw: 0,1,2,3,4,0
    tick(); chk("lw_s1", 8'(state), 8'd1); chk("lw_dec_srcb", 8'(alusrcb), 8'd3);
    tick(); chk("lw_s2", 8'(state), 8'd2); chk("lw_adr_srca", 8'(alusrca), 8'd1);
            chk("lw_adr_srcb", 8'(alusrcb), 8'd2);
    tick(); chk("lw_s3", 8'(state), 8'd3); chk("lw_rd_iord", 8'(iord), 8'd1);
            chk("lw_rd_regwr", 8'(regwrite), 8'd0);
    tick(); chk("lw_s4", 8'(state), 8'd4); chk("lw_wb_regwr", 8'(regwrite), 8'd1);
            chk("lw_wb_m2r", 8'(memtoreg), 8'd1);
    tick(); chk("lw_s0", 8'(state), 8'd0); chk("lw_end_regwr", 8'(regwrite), 8'd0);

    // R-type sub: 0,1,6,7,0
    op = 6'b000000; funct = 6'b100010;
    tick(); chk("sub_s1", 8'(state), 8'd1); chk("sub_illegal", 8'(illegal), 8'd0);
    tick(); chk("sub_s6", 8'(state), 8'd6); chk("sub_aluctl", 8'(alucontrol), 8'd6);
    tick(); chk("sub_s7", 8'(state), 8'd7); chk("sub_regdst", 8'(regdst), 8'd1);
            chk("sub_regwr", 8'(regwrite), 8'd1);
    tick(); chk("sub_s0", 8'(state), 8'd0);

    // beq with zero=1 takes the branch
    op = 6'b000100; zero = 1'b1;
    tick(); chk("beq_s1", 8'(state), 8'd1);
    tick(); chk("beq_s8", 8'(state), 8'd8); chk("beq_pcen", 8'(pcen), 8'd1);
            chk("beq_pcsrc", 8'(pcsrc), 8'd1); chk("beq_aluctl", 8'(alucontrol), 8'd6);
    tick(); chk("beq_s0", 8'(state), 8'd0);

    // bne with zero=1 does not branch; pcen follows zero combinationally
    op = 6'b000101;
    tick(); chk("bne_s1", 8'(state), 8'd1);
    tick(); chk("bne_s9", 8'(state), 8'd9); chk("bne_pcen_z1", 8'(pcen), 8'd0);
    zero = 1'b0; #1;
    chk("bne_pcen_z0", 8'(pcen), 8'd1);
    tick(); chk("bne_s0", 8'(state), 8'd0);

    // ori: zero-extended immediate, OR
    op = 6'b001101;
    tick(); chk("ori_s1", 8'(state), 8'd1);
    tick(); chk("ori_s10", 8'(state), 8'd10); chk("ori_soz", 8'(signorzero), 8'd1);
            chk("ori_aluctl", 8'(alucontrol), 8'd1);
    tick(); chk("ori_s11", 8'(state), 8'd11); chk("ori_regwr", 8'(regwrite), 8'd1);
    tick(); chk("ori_s0", 8'(state), 8'd0);

    // addi: sign-extended immediate, add
    op = 6'b001000;
    tick(); chk("addi_s1", 8'(state), 8'd1);
    tick(); chk("addi_s10", 8'(state), 8'd10); chk("addi_soz", 8'(signorzero), 8'd0);
            chk("addi_aluctl", 8'(alucontrol), 8'd2);
    tick(); chk("addi_s11", 8'(state), 8'd11);
    tick(); chk("addi_s0", 8'(state), 8'd0);

    // illegal opcode
    op = 6'b111111;
    tick(); chk("ilop_s1", 8'(state), 8'd1); chk("ilop_illegal", 8'(illegal), 8'd1);
            chk("ilop_regwr", 8'(regwrite), 8'd0); chk("ilop_memwr", 8'(memwrite), 8'd0);
    tick(); chk("ilop_s0", 8'(state), 8'd0); chk("ilop_clear", 8'(illegal), 8'd0);

    // illegal R funct
    op = 6'b000000; funct = 6'b000111;
    tick(); chk("ilfn_s1", 8'(state), 8'd1); chk("ilfn_illegal", 8'(illegal), 8'd1);
    tick(); chk("ilfn_s0", 8'(state), 8'd0); chk("ilfn_regwr", 8'(regwrite), 8'd0);

    // sw, reset mid-MEMWR
    op = 6'b101011;
    tick(); chk("sw_s1", 8'(state), 8'd1);
    tick(); chk("sw_s2", 8'(state), 8'd2);
    tick(); chk("sw_s5", 8'(state), 8'd5); chk("sw_memwr", 8'(memwrite), 8'd1);
            chk("sw_iord", 8'(iord), 8'd1);
    reset = 1'b1; #1;
    chk("abort_state", 8'(state), 8'd0);
    chk("abort_memwr", 8'(memwrite), 8'd0);
    chk("abort_pcen",  8'(pcen), 8'd0);
    @(negedge clk);
    chk("hold_state", 8'(state), 8'd0);
    reset = 1'b0;

    // j after reset
    op = 6'b000010;
    tick(); chk("j_s1", 8'(state), 8'd1);
    tick(); chk("j_s12", 8'(state), 8'd12); chk("j_pcsrc", 8'(pcsrc), 8'd2);
            chk("j_pcen", 8'(pcen), 8'd1);
    tick(); chk("j_s0", 8'(state), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
